// File: rtl/estado_mascota.sv
// Pet state decider: maps the four need levels and reaction pulses to a displayed
// state, tracks death by sustained critical needs, blinks a low-need alert, reports the weakest need.
module estado_mascota #(
    parameter int TIEMPO_CRITICO = 20,
    parameter int UMBRAL_FELIZ   = 10,
    parameter int UMBRAL_TRISTE  = 5,
    parameter int PERIODO_ALERTA = 4
) (
    input  logic       clk,
    input  logic       B_reset,
    input  logic [1:0] Nivel_hambre,
    input  logic [1:0] Nivel_energia,
    input  logic [1:0] Nivel_diversion,
    input  logic [1:0] Nivel_salud,
    input  logic [3:0] senal_reaccion,
    input  logic       dormir,
    output logic [2:0] Estado,
    output logic       Alerta,
    output logic       Muerto,
    output logic [1:0] Indice_critico
);

    typedef enum logic [2:0] {
        FELIZ      = 3'd0,
        NEUTRAL    = 3'd1,
        TRISTE     = 3'd2,
        HAMBRIENTO = 3'd3,
        CANSADO    = 3'd4,
        DORMIDO    = 3'd5,
        REACCION   = 3'd6,
        MUERTO     = 3'd7
    } estado_t;

    localparam int CW = $clog2(TIEMPO_CRITICO + 1);
    localparam int BW = (PERIODO_ALERTA > 1) ? $clog2(PERIODO_ALERTA) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(TIEMPO_CRITICO);
    localparam logic [BW-1:0] BLINK_MAX  = BW'(PERIODO_ALERTA - 1);
    localparam logic [3:0]    U_FELIZ    = 4'(UMBRAL_FELIZ);
    localparam logic [3:0]    U_TRISTE   = 4'(UMBRAL_TRISTE);

    estado_t         estado_q, estado_d;
    logic [CW-1:0]   crit_cnt_q, crit_cnt_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic            alerta_q, alerta_d;
    logic            muerto_q, muerto_d;
    logic [1:0]      indice_q, indice_d;

    logic [3:0]      suma;
    logic [2:0]      n_ceros;
    logic            critico;
    logic            nivel_bajo;
    logic            armado;
    logic [1:0]      min_nivel;

    always_comb begin
        suma = {2'b00, Nivel_hambre} + {2'b00, Nivel_energia}
             + {2'b00, Nivel_diversion} + {2'b00, Nivel_salud};
        n_ceros = {2'b00, Nivel_hambre == 2'd0} + {2'b00, Nivel_energia == 2'd0}
                + {2'b00, Nivel_diversion == 2'd0} + {2'b00, Nivel_salud == 2'd0};
        critico = (Nivel_salud == 2'd0) || (n_ceros >= 3'd2);
        nivel_bajo = (Nivel_hambre <= 2'd1) || (Nivel_energia <= 2'd1)
                   || (Nivel_diversion <= 2'd1) || (Nivel_salud <= 2'd1);
    end

    // Death counter freezes once dead but still clears if the condition goes away.
    always_comb begin
        crit_cnt_d = crit_cnt_q;
        if (!critico) begin
            crit_cnt_d = '0;
        end else if (estado_q != MUERTO && crit_cnt_q != CNT_MAX) begin
            crit_cnt_d = crit_cnt_q + 1'b1;
        end
    end

    always_comb begin
        estado_d = NEUTRAL;
        if (estado_q == MUERTO)               estado_d = MUERTO;
        else if (crit_cnt_q == CNT_MAX)       estado_d = MUERTO;
        else if (dormir)                      estado_d = DORMIDO;
        else if (senal_reaccion != 4'b0000)   estado_d = REACCION;
        else if (Nivel_hambre == 2'd0)        estado_d = HAMBRIENTO;
        else if (Nivel_energia == 2'd0)       estado_d = CANSADO;
        else if (suma >= U_FELIZ)             estado_d = FELIZ;
        else if (suma <= U_TRISTE)            estado_d = TRISTE;
        muerto_d = (estado_d == MUERTO);
    end

    // Blink counter wraps on the last count of each half-period, toggling the alert.
    always_comb begin
        armado   = nivel_bajo && (estado_d != MUERTO) && (estado_d != DORMIDO);
        blink_d  = '0;
        alerta_d = 1'b0;
        if (armado) begin
            if (blink_q == BLINK_MAX) begin
                blink_d  = '0;
                alerta_d = ~alerta_q;
            end else begin
                blink_d  = blink_q + 1'b1;
                alerta_d = alerta_q;
            end
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        indice_d  = 2'd0;
        min_nivel = Nivel_hambre;
        if (Nivel_energia < min_nivel) begin
            indice_d  = 2'd1;
            min_nivel = Nivel_energia;
        end
        if (Nivel_diversion < min_nivel) begin
            indice_d  = 2'd2;
            min_nivel = Nivel_diversion;
        end
        if (Nivel_salud < min_nivel) begin
            indice_d  = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge B_reset) begin
        if (!B_reset) begin
            estado_q   <= FELIZ;
            crit_cnt_q <= '0;
            blink_q    <= '0;
            alerta_q   <= 1'b0;
            muerto_q   <= 1'b0;
            indice_q   <= 2'd0;
        end else begin
            estado_q   <= estado_d;
            crit_cnt_q <= crit_cnt_d;
            blink_q    <= blink_d;
            alerta_q   <= alerta_d;
            muerto_q   <= muerto_d;
            indice_q   <= indice_d;
        end
    end

    assign Estado         = estado_q;
    assign Alerta         = alerta_q;
    assign Muerto         = muerto_q;
    assign Indice_critico = indice_q;

endmodule

// File: tb/tb_estado_mascota.sv
// Directed bench for estado_mascota: a per-cycle vector table plus hand-written
// sequences for async reset, death while asleep, critical-counter restart and death over reaction.
module tb_estado_mascota;

    logic       clk;
    logic       B_reset;
    logic [1:0] Nivel_hambre, Nivel_energia, Nivel_diversion, Nivel_salud;
    logic [3:0] senal_reaccion;
    logic       dormir;
    logic [2:0] Estado;
    logic       Alerta;
    logic       Muerto;
    logic [1:0] Indice_critico;

    int n_cmp  = 0;
    int n_fail = 0;

    estado_mascota dut (
        .clk            (clk),
        .B_reset        (B_reset),
        .Nivel_hambre   (Nivel_hambre),
        .Nivel_energia  (Nivel_energia),
        .Nivel_diversion(Nivel_diversion),
        .Nivel_salud    (Nivel_salud),
        .senal_reaccion (senal_reaccion),
        .dormir         (dormir),
        .Estado         (Estado),
        .Alerta         (Alerta),
        .Muerto         (Muerto),
        .Indice_critico (Indice_critico)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] h, e, d, s;
        logic [3:0] r;
        logic       dm;
        logic [2:0] est;
        logic       al;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic [1:0] h, e, d, s, input logic [3:0] r,
                                input logic dm, input logic [2:0] est, input logic al,
                                input logic [1:0] idx);
        vec_t v;
        v.h = h; v.e = e; v.d = d; v.s = s; v.r = r; v.dm = dm;
        v.est = est; v.al = al; v.idx = idx;
        return v;
    endfunction

    // driver tasks
    task automatic set_in(input logic [1:0] h, e, d, s, input logic [3:0] r, input logic dm);
        Nivel_hambre = h; Nivel_energia = e; Nivel_diversion = d; Nivel_salud = s;
        senal_reaccion = r; dormir = dm;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // scoreboard
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_estado"}, {5'd0, Estado}, 8'd0);
        check({tag, "_alerta"}, {7'd0, Alerta}, 8'd0);
        check({tag, "_muerto"}, {7'd0, Muerto}, 8'd0);
        check({tag, "_indice"}, {6'd0, Indice_critico}, 8'd0);
    endtask

    initial begin
        // h, e, d, s, reac, dormir -> estado, alerta, indice
        tbl[0]  = mk(3, 3, 3, 3, 4'b0000, 0, 3'd0, 0, 0);
        tbl[1]  = mk(2, 2, 1, 1, 4'b0000, 0, 3'd1, 0, 2);
        tbl[2]  = mk(2, 2, 1, 1, 4'b0000, 0, 3'd1, 0, 2);
        tbl[3]  = mk(2, 2, 1, 1, 4'b0000, 0, 3'd1, 0, 2);
        tbl[4]  = mk(2, 2, 1, 1, 4'b0000, 0, 3'd1, 1, 2);
        tbl[5]  = mk(1, 1, 1, 1, 4'b0000, 0, 3'd2, 1, 0);
        tbl[6]  = mk(1, 1, 1, 1, 4'b0000, 0, 3'd2, 1, 0);
        tbl[7]  = mk(1, 1, 1, 1, 4'b0000, 0, 3'd2, 1, 0);
        tbl[8]  = mk(1, 1, 1, 1, 4'b0000, 0, 3'd2, 0, 0);
        tbl[9]  = mk(0, 3, 3, 3, 4'b0000, 0, 3'd3, 0, 0);
        tbl[10] = mk(3, 3, 3, 3, 4'b0000, 0, 3'd0, 0, 0);
        tbl[11] = mk(1, 1, 2, 3, 4'b0000, 0, 3'd1, 0, 0);
        tbl[12] = mk(3, 2, 2, 1, 4'b0000, 0, 3'd1, 0, 3);
        tbl[13] = mk(3, 3, 3, 3, 4'b0100, 0, 3'd6, 0, 0);
        tbl[14] = mk(3, 3, 3, 3, 4'b0100, 0, 3'd6, 0, 0);
        tbl[15] = mk(3, 3, 3, 3, 4'b0100, 0, 3'd6, 0, 0);
        tbl[16] = mk(3, 3, 3, 3, 4'b0000, 0, 3'd0, 0, 0);
        tbl[17] = mk(3, 3, 3, 3, 4'b0100, 1, 3'd5, 0, 0);
        tbl[18] = mk(3, 3, 3, 3, 4'b0100, 1, 3'd5, 0, 0);
        tbl[19] = mk(3, 3, 3, 3, 4'b0000, 0, 3'd0, 0, 0);
        tbl[20] = mk(3, 0, 3, 3, 4'b0000, 0, 3'd4, 0, 1);
        tbl[21] = mk(3, 3, 3, 2, 4'b0000, 0, 3'd0, 0, 3);
        tbl[22] = mk(2, 3, 2, 3, 4'b0000, 0, 3'd0, 0, 0);
        tbl[23] = mk(2, 2, 2, 3, 4'b0000, 0, 3'd1, 0, 0);
        tbl[24] = mk(2, 1, 1, 1, 4'b0000, 0, 3'd2, 0, 1);
        tbl[25] = mk(3, 3, 3, 3, 4'b0000, 0, 3'd0, 0, 0);

        B_reset = 1'b0;
        set_in(3, 3, 3, 3, 4'b0000, 0);
        repeat (2) tick;
        check_reset_vals("reset");
        B_reset = 1'b1;

        foreach (tbl[i]) begin
            set_in(tbl[i].h, tbl[i].e, tbl[i].d, tbl[i].s, tbl[i].r, tbl[i].dm);
            tick;
            check($sformatf("vec%0d_estado", i), {5'd0, Estado}, {5'd0, tbl[i].est});
            check($sformatf("vec%0d_alerta", i), {7'd0, Alerta}, {7'd0, tbl[i].al});
            check($sformatf("vec%0d_indice", i), {6'd0, Indice_critico}, {6'd0, tbl[i].idx});
            check($sformatf("vec%0d_muerto", i), {7'd0, Muerto}, {7'd0, tbl[i].est == 3'd7});
        end

        // asynchronous reset in the middle of a cycle, no clock edge needed
        set_in(1, 1, 1, 1, 4'b0000, 0);
        repeat (5) tick;
        check("pre_async_estado", {5'd0, Estado}, 8'd2);
        check("pre_async_alerta", {7'd0, Alerta}, 8'd1);
        #2 B_reset = 1'b0;
        #1;
        check_reset_vals("async");

        // health 0 while asleep: DORMIDO for 20 edges, then MUERTO
        set_in(3, 3, 3, 0, 4'b0000, 1);
        tick;
        B_reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            check($sformatf("sleep_crit%0d_estado", k), {5'd0, Estado}, 8'd5);
            check($sformatf("sleep_crit%0d_alerta", k), {7'd0, Alerta}, 8'd0);
        end
        tick;
        check("death_estado", {5'd0, Estado}, 8'd7);
        check("death_muerto", {7'd0, Muerto}, 8'd1);
        check("death_alerta", {7'd0, Alerta}, 8'd0);
        check("death_indice", {6'd0, Indice_critico}, 8'd3);
        set_in(3, 3, 3, 3, 4'b0000, 0);
        repeat (3) tick;
        check("dead_stays_estado", {5'd0, Estado}, 8'd7);
        check("dead_stays_muerto", {7'd0, Muerto}, 8'd1);
        check("dead_indice", {6'd0, Indice_critico}, 8'd0);
        B_reset = 1'b0;
        #1;
        check_reset_vals("dead_reset");

        // two zeros for 19 edges, one edge of relief, then 20 more before death
        tick;
        B_reset = 1'b1;
        set_in(0, 0, 3, 3, 4'b0000, 0);
        for (int k = 1; k <= 19; k++) begin
            tick;
            check($sformatf("crit_a%0d_estado", k), {5'd0, Estado}, 8'd3);
        end
        set_in(3, 0, 3, 3, 4'b0000, 0);
        tick;
        check("relief_estado", {5'd0, Estado}, 8'd4);
        set_in(0, 0, 3, 3, 4'b0000, 0);
        for (int k = 1; k <= 20; k++) begin
            tick;
            check($sformatf("crit_b%0d_estado", k), {5'd0, Estado}, 8'd3);
        end
        tick;
        check("restart_death_estado", {5'd0, Estado}, 8'd7);
        check("restart_death_muerto", {7'd0, Muerto}, 8'd1);

        // death wins over a held reaction pulse
        B_reset = 1'b0;
        tick;
        B_reset = 1'b1;
        set_in(3, 3, 3, 0, 4'b0001, 0);
        for (int k = 1; k <= 20; k++) begin
            tick;
            check($sformatf("reac_crit%0d_estado", k), {5'd0, Estado}, 8'd6);
        end
        tick;
        check("reac_death_estado", {5'd0, Estado}, 8'd7);
        check("reac_death_muerto", {7'd0, Muerto}, 8'd1);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
